// File: rtl/compute_cluster_mem.sv
// Sparse int8 MAC cluster: IFM/filter SRAMs, double-buffered chunk registers, per-unit accumulators.
// Start-to-end latency equals the summed (matches+1) over the processed segments; there is no backpressure.
module compute_cluster_mem #(
  parameter int BUS_SIZE         = 16,
  parameter int WR_DAT_CYC_NUM   = 4,
  parameter int SRAM_IFM_NUM     = 64,
  parameter int SRAM_FILTER_NUM  = 64,
  parameter int COMPUTE_UNIT_NUM = 2,
  parameter int OUTPUT_BUF_NUM   = 16,
  parameter int OUTPUT_BUF_SIZE  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 ifm_chunk_wr_valid_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]    ifm_chunk_wr_count_i,
  input  logic                                 ifm_chunk_wr_sel_i,
  input  logic                                 ifm_chunk_rd_sel_i,
  input  logic [$clog2(SRAM_IFM_NUM)-1:0]      ifm_sram_rd_count_i,
  input  logic                                 fil_chunk_wr_valid_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]    fil_chunk_wr_count_i,
  input  logic                                 fil_chunk_wr_sel_i,
  input  logic                                 fil_chunk_rd_sel_i,
  input  logic [COMPUTE_UNIT_NUM-1:0]          fil_chunk_cu_wr_sel_i,
  input  logic [$clog2(SRAM_FILTER_NUM)-1:0]   fil_sram_rd_count_i,
  input  logic                                 run_valid_i,
  input  logic                                 total_chunk_start_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]    rd_fil_sparsemap_last_i,
  output logic                                 total_chunk_end_o,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]    acc_buf_sel_i,
  input  logic [$clog2(COMPUTE_UNIT_NUM)-1:0]  com_unit_out_buf_sel_i,
  output logic [OUTPUT_BUF_SIZE-1:0]           out_buf_dat_o,
  input  logic [BUS_SIZE-1:0]                  ifm_sram_wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                ifm_sram_wr_nonzero_data_i,
  input  logic                                 ifm_sram_wr_valid_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]    ifm_sram_wr_dat_count_i,
  input  logic [$clog2(SRAM_IFM_NUM)-1:0]      ifm_sram_wr_chunk_count_i,
  input  logic [BUS_SIZE-1:0]                  fil_sram_wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                fil_sram_wr_nonzero_data_i,
  input  logic                                 fil_sram_wr_valid_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0]    fil_sram_wr_dat_count_i,
  input  logic [$clog2(SRAM_FILTER_NUM)-1:0]   fil_sram_wr_chunk_count_i
);

  localparam int CHUNK  = BUS_SIZE * WR_DAT_CYC_NUM;
  localparam int BEAT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int BIT_W  = $clog2(BUS_SIZE);
  localparam int POS_W  = BEAT_W + BIT_W;
  localparam int ACC_AW = $clog2(OUTPUT_BUF_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} unit_state_t;

  logic [BUS_SIZE-1:0]   ifm_sram_sm  [SRAM_IFM_NUM][WR_DAT_CYC_NUM];
  logic [BUS_SIZE*8-1:0] ifm_sram_dat [SRAM_IFM_NUM][WR_DAT_CYC_NUM];
  logic [BUS_SIZE-1:0]   fil_sram_sm  [SRAM_FILTER_NUM][WR_DAT_CYC_NUM];
  logic [BUS_SIZE*8-1:0] fil_sram_dat [SRAM_FILTER_NUM][WR_DAT_CYC_NUM];

  logic [CHUNK-1:0]      ifm_buf_sm  [2];
  logic [CHUNK*8-1:0]    ifm_buf_dat [2];
  logic [CHUNK-1:0]      fil_buf_sm  [COMPUTE_UNIT_NUM][2];
  logic [CHUNK*8-1:0]    fil_buf_dat [COMPUTE_UNIT_NUM][2];

  unit_state_t           st      [COMPUTE_UNIT_NUM];
  logic [BEAT_W-1:0]     seg     [COMPUTE_UNIT_NUM];
  logic [BUS_SIZE-1:0]   mask    [COMPUTE_UNIT_NUM];
  logic                  ird_sel [COMPUTE_UNIT_NUM];
  logic                  frd_sel [COMPUTE_UNIT_NUM];
  logic [ACC_AW-1:0]     acc_sel [COMPUTE_UNIT_NUM];
  logic [BEAT_W-1:0]     last    [COMPUTE_UNIT_NUM];
  logic [OUTPUT_BUF_SIZE-1:0] acc [COMPUTE_UNIT_NUM][OUTPUT_BUF_NUM];

  logic [BUS_SIZE-1:0]        match    [COMPUTE_UNIT_NUM];
  logic [BIT_W-1:0]           hit_bit  [COMPUTE_UNIT_NUM];
  logic [POS_W-1:0]           hit_pos  [COMPUTE_UNIT_NUM];
  logic [POS_W-1:0]           ifm_idx  [COMPUTE_UNIT_NUM];
  logic [POS_W-1:0]           fil_idx  [COMPUTE_UNIT_NUM];
  logic signed [7:0]          ifm_val  [COMPUTE_UNIT_NUM];
  logic signed [7:0]          fil_val  [COMPUTE_UNIT_NUM];
  logic signed [15:0]         mul      [COMPUTE_UNIT_NUM];
  logic [OUTPUT_BUF_SIZE-1:0] acc_inc  [COMPUTE_UNIT_NUM];
  logic [COMPUTE_UNIT_NUM-1:0] unit_fin;
  logic                        all_idle;
  logic                        fin_all;
  logic                        start_ok;

  // Packed byte index of a nonzero element = number of set sparsemap bits below it.
  function automatic logic [POS_W-1:0] prefix_pop(input logic [CHUNK-1:0] sm,
                                                  input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i < int'(pos)) cnt = cnt + POS_W'(sm[i]);
    end
    return cnt;
  endfunction

  function automatic logic [BIT_W-1:0] lowest_set(input logic [BUS_SIZE-1:0] v);
    logic [BIT_W-1:0] r;
    r = '0;
    for (int i = BUS_SIZE - 1; i >= 0; i--) begin
      if (v[i]) r = BIT_W'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (ifm_sram_wr_valid_i) begin
      ifm_sram_sm[ifm_sram_wr_chunk_count_i][ifm_sram_wr_dat_count_i]  <= ifm_sram_wr_sparsemap_i;
      ifm_sram_dat[ifm_sram_wr_chunk_count_i][ifm_sram_wr_dat_count_i] <= ifm_sram_wr_nonzero_data_i;
    end
    if (fil_sram_wr_valid_i) begin
      fil_sram_sm[fil_sram_wr_chunk_count_i][fil_sram_wr_dat_count_i]  <= fil_sram_wr_sparsemap_i;
      fil_sram_dat[fil_sram_wr_chunk_count_i][fil_sram_wr_dat_count_i] <= fil_sram_wr_nonzero_data_i;
    end
  end

  // Beat k of an SRAM entry lands in bits/bytes [k*BUS_SIZE +: BUS_SIZE] of the chunk buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        ifm_buf_sm[b]  <= '0;
        ifm_buf_dat[b] <= '0;
        for (int u = 0; u < COMPUTE_UNIT_NUM; u++) begin
          fil_buf_sm[u][b]  <= '0;
          fil_buf_dat[u][b] <= '0;
        end
      end
    end else begin
      if (ifm_chunk_wr_valid_i) begin
        ifm_buf_sm[ifm_chunk_wr_sel_i][ifm_chunk_wr_count_i*BUS_SIZE +: BUS_SIZE] <=
          ifm_sram_sm[ifm_sram_rd_count_i][ifm_chunk_wr_count_i];
        ifm_buf_dat[ifm_chunk_wr_sel_i][ifm_chunk_wr_count_i*BUS_SIZE*8 +: BUS_SIZE*8] <=
          ifm_sram_dat[ifm_sram_rd_count_i][ifm_chunk_wr_count_i];
      end
      for (int u = 0; u < COMPUTE_UNIT_NUM; u++) begin
        if (fil_chunk_wr_valid_i && fil_chunk_cu_wr_sel_i[u]) begin
          fil_buf_sm[u][fil_chunk_wr_sel_i][fil_chunk_wr_count_i*BUS_SIZE +: BUS_SIZE] <=
            fil_sram_sm[fil_sram_rd_count_i][fil_chunk_wr_count_i];
          fil_buf_dat[u][fil_chunk_wr_sel_i][fil_chunk_wr_count_i*BUS_SIZE*8 +: BUS_SIZE*8] <=
            fil_sram_dat[fil_sram_rd_count_i][fil_chunk_wr_count_i];
        end
      end
    end
  end

  always_comb begin
    all_idle = 1'b1;
    unit_fin = '0;
    for (int u = 0; u < COMPUTE_UNIT_NUM; u++) begin
      match[u]   = ifm_buf_sm[ird_sel[u]][seg[u]*BUS_SIZE +: BUS_SIZE]
                 & fil_buf_sm[u][frd_sel[u]][seg[u]*BUS_SIZE +: BUS_SIZE]
                 & ~mask[u];
      hit_bit[u] = lowest_set(match[u]);
      hit_pos[u] = {seg[u], hit_bit[u]};
      ifm_idx[u] = prefix_pop(ifm_buf_sm[ird_sel[u]], hit_pos[u]);
      fil_idx[u] = prefix_pop(fil_buf_sm[u][frd_sel[u]], hit_pos[u]);
      ifm_val[u] = ifm_buf_dat[ird_sel[u]][8*int'(ifm_idx[u]) +: 8];
      fil_val[u] = fil_buf_dat[u][frd_sel[u]][8*int'(fil_idx[u]) +: 8];
      mul[u]     = ifm_val[u] * fil_val[u];
      acc_inc[u] = {{(OUTPUT_BUF_SIZE-16){mul[u][15]}}, mul[u]};
      unit_fin[u] = (st[u] == ST_DONE) ||
                    ((st[u] == ST_RUN) && (match[u] == '0) && (seg[u] == last[u]));
      if (st[u] != ST_IDLE) all_idle = 1'b0;
    end
    fin_all  = &unit_fin;
    start_ok = all_idle && total_chunk_start_i && run_valid_i;
  end

  // Units finishing early park in DONE; the whole cluster returns to IDLE together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_chunk_end_o <= 1'b0;
      for (int u = 0; u < COMPUTE_UNIT_NUM; u++) begin
        st[u]      <= ST_IDLE;
        seg[u]     <= '0;
        mask[u]    <= '0;
        ird_sel[u] <= 1'b0;
        frd_sel[u] <= 1'b0;
        acc_sel[u] <= '0;
        last[u]    <= '0;
        for (int i = 0; i < OUTPUT_BUF_NUM; i++) acc[u][i] <= '0;
      end
    end else begin
      total_chunk_end_o <= fin_all;
      for (int u = 0; u < COMPUTE_UNIT_NUM; u++) begin
        case (st[u])
          ST_IDLE: begin
            if (start_ok) begin
              ird_sel[u] <= ifm_chunk_rd_sel_i;
              frd_sel[u] <= fil_chunk_rd_sel_i;
              acc_sel[u] <= acc_buf_sel_i;
              last[u]    <= rd_fil_sparsemap_last_i;
              seg[u]     <= '0;
              mask[u]    <= '0;
              st[u]      <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (match[u] != '0) begin
              acc[u][acc_sel[u]]  <= acc[u][acc_sel[u]] + acc_inc[u];
              mask[u][hit_bit[u]] <= 1'b1;
            end else if (seg[u] == last[u]) begin
              st[u] <= ST_DONE;
            end else begin
              seg[u]  <= seg[u] + BEAT_W'(1);
              mask[u] <= '0;
            end
          end
          ST_DONE: ;
          default: st[u] <= ST_IDLE;
        endcase
        if (fin_all) st[u] <= ST_IDLE;
      end
    end
  end

  assign out_buf_dat_o = acc[com_unit_out_buf_sel_i][acc_buf_sel_i];

endmodule

// File: tb/tb_compute_cluster_mem.sv
// Scoreboarded bench: a chunk-level reference model predicts end-pulse timing and accumulator contents.
module tb_compute_cluster_mem;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic         ifm_chunk_wr_valid_i, ifm_chunk_wr_sel_i, ifm_chunk_rd_sel_i;
  logic [1:0]   ifm_chunk_wr_count_i;
  logic [5:0]   ifm_sram_rd_count_i;
  logic         fil_chunk_wr_valid_i, fil_chunk_wr_sel_i, fil_chunk_rd_sel_i;
  logic [1:0]   fil_chunk_wr_count_i;
  logic [1:0]   fil_chunk_cu_wr_sel_i;
  logic [5:0]   fil_sram_rd_count_i;
  logic         run_valid_i, total_chunk_start_i;
  logic [1:0]   rd_fil_sparsemap_last_i;
  logic         total_chunk_end_o;
  logic [3:0]   acc_buf_sel_i;
  logic [0:0]   com_unit_out_buf_sel_i;
  logic [31:0]  out_buf_dat_o;
  logic [15:0]  ifm_sram_wr_sparsemap_i, fil_sram_wr_sparsemap_i;
  logic [127:0] ifm_sram_wr_nonzero_data_i, fil_sram_wr_nonzero_data_i;
  logic         ifm_sram_wr_valid_i, fil_sram_wr_valid_i;
  logic [1:0]   ifm_sram_wr_dat_count_i, fil_sram_wr_dat_count_i;
  logic [5:0]   ifm_sram_wr_chunk_count_i, fil_sram_wr_chunk_count_i;

  compute_cluster_mem dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifm_chunk_wr_valid_i(ifm_chunk_wr_valid_i), .ifm_chunk_wr_count_i(ifm_chunk_wr_count_i),
    .ifm_chunk_wr_sel_i(ifm_chunk_wr_sel_i), .ifm_chunk_rd_sel_i(ifm_chunk_rd_sel_i),
    .ifm_sram_rd_count_i(ifm_sram_rd_count_i),
    .fil_chunk_wr_valid_i(fil_chunk_wr_valid_i), .fil_chunk_wr_count_i(fil_chunk_wr_count_i),
    .fil_chunk_wr_sel_i(fil_chunk_wr_sel_i), .fil_chunk_rd_sel_i(fil_chunk_rd_sel_i),
    .fil_chunk_cu_wr_sel_i(fil_chunk_cu_wr_sel_i), .fil_sram_rd_count_i(fil_sram_rd_count_i),
    .run_valid_i(run_valid_i), .total_chunk_start_i(total_chunk_start_i),
    .rd_fil_sparsemap_last_i(rd_fil_sparsemap_last_i), .total_chunk_end_o(total_chunk_end_o),
    .acc_buf_sel_i(acc_buf_sel_i), .com_unit_out_buf_sel_i(com_unit_out_buf_sel_i),
    .out_buf_dat_o(out_buf_dat_o),
    .ifm_sram_wr_sparsemap_i(ifm_sram_wr_sparsemap_i), .ifm_sram_wr_nonzero_data_i(ifm_sram_wr_nonzero_data_i),
    .ifm_sram_wr_valid_i(ifm_sram_wr_valid_i), .ifm_sram_wr_dat_count_i(ifm_sram_wr_dat_count_i),
    .ifm_sram_wr_chunk_count_i(ifm_sram_wr_chunk_count_i),
    .fil_sram_wr_sparsemap_i(fil_sram_wr_sparsemap_i), .fil_sram_wr_nonzero_data_i(fil_sram_wr_nonzero_data_i),
    .fil_sram_wr_valid_i(fil_sram_wr_valid_i), .fil_sram_wr_dat_count_i(fil_sram_wr_dat_count_i),
    .fil_sram_wr_chunk_count_i(fil_sram_wr_chunk_count_i)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          end_q[$];
  logic [31:0] rd_q[$];
  logic        rd_vld = 1'b0;
  int          exp_end;
  logic [31:0] exp_rd;

  // Reference model: whole chunks as 64-bit sparsemaps and 64-byte data vectors.
  logic [63:0]  m_isram_sm [64];
  logic [511:0] m_isram_dat[64];
  logic [63:0]  m_fsram_sm [64];
  logic [511:0] m_fsram_dat[64];
  logic [63:0]  m_ibuf_sm  [2];
  logic [511:0] m_ibuf_dat [2];
  logic [63:0]  m_fbuf_sm  [2][2];
  logic [511:0] m_fbuf_dat [2][2];
  logic [31:0]  m_acc      [2][16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (total_chunk_end_o) begin
        if (end_q.size() == 0) begin
          checks++;
          $display("FAIL end_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          exp_end = end_q.pop_front();
          check("end_cycle", cyc, exp_end);
        end
      end
      if (rd_vld) begin
        exp_rd = rd_q.pop_front();
        check("acc_read", out_buf_dat_o, exp_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pop_below(input logic [63:0] sm, input int p);
    int c = 0;
    for (int i = 0; i < p; i++) c += int'(sm[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      m_ibuf_sm[u] = '0;
      m_ibuf_dat[u] = '0;
      for (int b = 0; b < 2; b++) begin
        m_fbuf_sm[u][b] = '0;
        m_fbuf_dat[u][b] = '0;
      end
      for (int i = 0; i < 16; i++) m_acc[u][i] = '0;
    end
  endtask

  task automatic load_sram(input bit fil, input int entry, input logic [63:0] sm, input logic [511:0] dat);
    for (int k = 0; k < 4; k++) begin
      if (fil) begin
        fil_sram_wr_valid_i = 1'b1;  fil_sram_wr_dat_count_i = 2'(k);
        fil_sram_wr_chunk_count_i = 6'(entry);
        fil_sram_wr_sparsemap_i = sm[k*16 +: 16];  fil_sram_wr_nonzero_data_i = dat[k*128 +: 128];
      end else begin
        ifm_sram_wr_valid_i = 1'b1;  ifm_sram_wr_dat_count_i = 2'(k);
        ifm_sram_wr_chunk_count_i = 6'(entry);
        ifm_sram_wr_sparsemap_i = sm[k*16 +: 16];  ifm_sram_wr_nonzero_data_i = dat[k*128 +: 128];
      end
      tick();
    end
    fil_sram_wr_valid_i = 1'b0;
    ifm_sram_wr_valid_i = 1'b0;
    if (fil) begin m_fsram_sm[entry] = sm; m_fsram_dat[entry] = dat; end
    else     begin m_isram_sm[entry] = sm; m_isram_dat[entry] = dat; end
  endtask

  task automatic copy_chunk(input bit fil, input int entry, input bit sel, input logic [1:0] cu);
    for (int k = 0; k < 4; k++) begin
      if (fil) begin
        fil_chunk_wr_valid_i = 1'b1; fil_chunk_wr_count_i = 2'(k);
        fil_chunk_wr_sel_i = sel; fil_sram_rd_count_i = 6'(entry); fil_chunk_cu_wr_sel_i = cu;
      end else begin
        ifm_chunk_wr_valid_i = 1'b1; ifm_chunk_wr_count_i = 2'(k);
        ifm_chunk_wr_sel_i = sel; ifm_sram_rd_count_i = 6'(entry);
      end
      tick();
    end
    fil_chunk_wr_valid_i = 1'b0;
    ifm_chunk_wr_valid_i = 1'b0;
    if (fil) begin
      for (int u = 0; u < 2; u++)
        if (cu[u]) begin m_fbuf_sm[u][sel] = m_fsram_sm[entry]; m_fbuf_dat[u][sel] = m_fsram_dat[entry]; end
    end else begin
      m_ibuf_sm[sel] = m_isram_sm[entry];
      m_ibuf_dat[sel] = m_isram_dat[entry];
    end
  endtask

  task automatic start_run(input bit isel, input bit fsel, input int asel, input int last);
    int lat_max = 0;
    for (int u = 0; u < 2; u++) begin
      int lat = 0;
      for (int s = 0; s <= last; s++) begin
        for (int b = 0; b < 16; b++) begin
          int p = s * 16 + b;
          if (m_ibuf_sm[isel][p] && m_fbuf_sm[u][fsel][p]) begin
            logic [7:0] iv, fv;
            iv = m_ibuf_dat[isel][8*pop_below(m_ibuf_sm[isel], p) +: 8];
            fv = m_fbuf_dat[u][fsel][8*pop_below(m_fbuf_sm[u][fsel], p) +: 8];
            m_acc[u][asel] = m_acc[u][asel] + 32'(int'($signed(iv)) * int'($signed(fv)));
            lat++;
          end
        end
        lat++;
      end
      if (lat > lat_max) lat_max = lat;
    end
    ifm_chunk_rd_sel_i = isel;  fil_chunk_rd_sel_i = fsel;
    acc_buf_sel_i = 4'(asel);   rd_fil_sparsemap_last_i = 2'(last);
    run_valid_i = 1'b1;         total_chunk_start_i = 1'b1;
    tick();
    total_chunk_start_i = 1'b0;
    end_q.push_back(cyc + lat_max);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 400 && end_q.size() != 0; i++) tick();
    if (end_q.size() != 0) begin
      checks++;
      $display("FAIL end_timeout: %0d end pulses still pending, expected 0", end_q.size());
      end_q.delete();
    end
  endtask

  task automatic read_acc(input int u, input int idx);
    com_unit_out_buf_sel_i = 1'(u);
    acc_buf_sel_i = 4'(idx);
    rd_q.push_back(m_acc[u][idx]);
    rd_vld = 1'b1;
    tick();
    rd_vld = 1'b0;
  endtask

  task automatic gen_chunk(input int density, output logic [63:0] sm, output logic [511:0] dat);
    for (int i = 0; i < 64; i++) sm[i] = (int'($urandom_range(99)) < density);
    for (int j = 0; j < 16; j++) dat[j*32 +: 32] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [63:0]  sm, sm2;
    logic [511:0] dat, dat2;
    ifm_chunk_wr_valid_i = 0; ifm_chunk_wr_count_i = 0; ifm_chunk_wr_sel_i = 0; ifm_chunk_rd_sel_i = 0;
    ifm_sram_rd_count_i = 0; fil_chunk_wr_valid_i = 0; fil_chunk_wr_count_i = 0; fil_chunk_wr_sel_i = 0;
    fil_chunk_rd_sel_i = 0; fil_chunk_cu_wr_sel_i = 0; fil_sram_rd_count_i = 0; run_valid_i = 0;
    total_chunk_start_i = 0; rd_fil_sparsemap_last_i = 0; acc_buf_sel_i = 0; com_unit_out_buf_sel_i = 0;
    ifm_sram_wr_sparsemap_i = 0; ifm_sram_wr_nonzero_data_i = 0; ifm_sram_wr_valid_i = 0;
    ifm_sram_wr_dat_count_i = 0; ifm_sram_wr_chunk_count_i = 0; fil_sram_wr_sparsemap_i = 0;
    fil_sram_wr_nonzero_data_i = 0; fil_sram_wr_valid_i = 0; fil_sram_wr_dat_count_i = 0;
    fil_sram_wr_chunk_count_i = 0;
    model_clear();
    rst_i = 1'b1;
    repeat (100) tick();
    check("end_in_reset", 32'(total_chunk_end_o), 32'd0);
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) begin
        com_unit_out_buf_sel_i = 1'(u); acc_buf_sel_i = 4'(i); #1;
        check("acc_in_reset", out_buf_dat_o, 32'd0);
      end
    rst_i = 1'b0;
    tick();

    // All-ones IFM of 2s against a single filter nonzero of 3, unit 0 only.
    load_sram(0, 0, '1, {64{8'd2}});
    load_sram(1, 0, 64'h1, {64{8'd3}});
    copy_chunk(0, 0, 0, 2'b00);
    copy_chunk(1, 0, 0, 2'b01);
    start_run(0, 0, 5, 3);
    wait_end();
    read_acc(0, 5);
    read_acc(1, 5);

    // Disjoint sparsemaps in the other buffers.
    load_sram(0, 1, 64'h1, {64{8'd7}});
    load_sram(1, 1, 64'h2, {64{8'd9}});
    copy_chunk(0, 1, 1, 2'b00);
    copy_chunk(1, 1, 1, 2'b11);
    start_run(1, 1, 5, 0);
    wait_end();
    read_acc(0, 5);
    read_acc(1, 5);

    // Signed extremes, accumulated across two starts, then a negative product.
    load_sram(0, 2, 64'h1, {{63{8'h00}}, 8'h80});
    load_sram(1, 2, 64'h1, {{63{8'h00}}, 8'h80});
    copy_chunk(0, 2, 0, 2'b00);
    copy_chunk(1, 2, 0, 2'b11);
    start_run(0, 0, 7, 0); wait_end();
    start_run(0, 0, 7, 0); wait_end();
    read_acc(0, 7);
    read_acc(1, 7);
    load_sram(0, 3, 64'h1, {{63{8'h00}}, 8'hFF});
    load_sram(1, 3, 64'h1, {{63{8'h00}}, 8'h05});
    copy_chunk(0, 3, 0, 2'b00);
    copy_chunk(1, 3, 0, 2'b11);
    start_run(0, 0, 7, 0); wait_end();
    read_acc(0, 7);
    read_acc(1, 7);

    // Three matches in segment 0, two in segment 1; a match in segment 2 lies beyond last.
    gen_chunk(0, sm, dat);
    gen_chunk(0, sm2, dat2);
    sm  = 64'h0000_0100_0011_00A9;
    sm2 = 64'h0000_0100_0011_0229;
    load_sram(0, 4, sm, dat);
    load_sram(1, 4, sm2, dat2);
    copy_chunk(0, 4, 1, 2'b00);
    copy_chunk(1, 4, 1, 2'b01);
    start_run(1, 1, 9, 1);
    tick(); tick();
    total_chunk_start_i = 1'b1; run_valid_i = 1'b1;
    tick();
    total_chunk_start_i = 1'b0;
    wait_end();
    read_acc(0, 9);
    read_acc(1, 9);

    // Start without run_valid must be ignored.
    run_valid_i = 1'b0; total_chunk_start_i = 1'b1;
    tick();
    total_chunk_start_i = 1'b0;
    repeat (10) tick();

    for (int it = 0; it < 40; it++) begin
      int ie, fe;
      bit isel, fsel;
      ie = int'($urandom_range(63));
      fe = int'($urandom_range(63));
      gen_chunk(int'($urandom_range(10, 90)), sm, dat);
      gen_chunk(int'($urandom_range(10, 90)), sm2, dat2);
      load_sram(0, ie, sm, dat);
      load_sram(1, fe, sm2, dat2);
      isel = 1'($urandom_range(1));
      fsel = 1'($urandom_range(1));
      copy_chunk(0, ie, isel, 2'b00);
      copy_chunk(1, fe, fsel, 2'($urandom_range(1, 3)));
      start_run(isel, fsel, int'($urandom_range(15)), int'($urandom_range(3)));
      wait_end();
      read_acc(0, int'($urandom_range(15)));
      read_acc(1, int'($urandom_range(15)));
    end

    // Reset in the middle of a long run: no end pulse, everything cleared.
    load_sram(0, 5, '1, {16{$urandom}});
    load_sram(1, 5, '1, {16{$urandom}});
    copy_chunk(0, 5, 0, 2'b00);
    copy_chunk(1, 5, 0, 2'b11);
    start_run(0, 0, 3, 3);
    repeat (5) tick();
    rst_i = 1'b1;
    end_q.delete();
    model_clear();
    tick();
    check("end_mid_reset", 32'(total_chunk_end_o), 32'd0);
    tick();
    rst_i = 1'b0;
    repeat (80) tick();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) read_acc(u, i);
    start_run(0, 0, 3, 3);
    wait_end();
    read_acc(0, 3);

    repeat (5) tick();
    check("end_queue_drained", 32'(end_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
